// File: rtl/copiador_memoria_pkg.sv
// ============================================================================
// Module   : copiador_memoria_pkg
// Desc     : Shared FSM state encodings and memory geometry for the copier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package copiador_memoria_pkg;

  localparam int MEM_PROFUNDIDAD = 64;
  localparam int MEM_ANCHO_DATO  = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LEER     = 3'd1;
  localparam logic [2:0] S_PREP     = 3'd2;
  localparam logic [2:0] S_ESCRIBIR = 3'd3;
  localparam logic [2:0] S_LIBERAR  = 3'd4;
  localparam logic [2:0] S_FIN      = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

endpackage

`default_nettype wire

// File: rtl/copiador_memoria.sv
// ============================================================================
// Module   : copiador_memoria
// Desc     : Word-by-word memory block copier (simple DMA) driving Memoria.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module copiador_memoria
  import copiador_memoria_pkg::*;
#(
  parameter int ANCHO_DATO  = MEM_ANCHO_DATO,
  parameter int ANCHO_DIR   = 32,
  parameter int PROFUNDIDAD = MEM_PROFUNDIDAD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [ANCHO_DIR-1:0]  origen,
  input  logic [ANCHO_DIR-1:0]  destino,
  input  logic [ANCHO_DIR-1:0]  longitud,
  input  logic [ANCHO_DATO-1:0] salida,
  output logic [ANCHO_DATO-1:0] dato,
  output logic [ANCHO_DIR-1:0]  direccion,
  output logic                  sel,
  output logic                  ocupado,
  output logic                  listo,
  output logic                  error
);

  localparam logic [ANCHO_DIR-1:0] PROF   = ANCHO_DIR'(PROFUNDIDAD);
  localparam logic [ANCHO_DIR-1:0] ULTIMO = ANCHO_DIR'(PROFUNDIDAD - 1);
  localparam logic [ANCHO_DIR-1:0] UNO    = ANCHO_DIR'(1);

  logic [2:0]            estado_q, estado_d;
  logic [ANCHO_DIR-1:0]  src_q, src_d;
  logic [ANCHO_DIR-1:0]  dst_q, dst_d;
  logic [ANCHO_DIR-1:0]  rest_q, rest_d;
  logic [ANCHO_DATO-1:0] dato_q, dato_d;
  logic [ANCHO_DIR-1:0]  direccion_q, direccion_d;
  logic                  sel_q, sel_d;
  logic                  ocupado_q, ocupado_d;
  logic                  listo_q, listo_d;
  logic                  error_q, error_d;

  function automatic logic [ANCHO_DIR-1:0] siguiente(input logic [ANCHO_DIR-1:0] a);
    return (a == ULTIMO) ? '0 : a + UNO;
  endfunction

  // Outputs are computed for the state being entered, so every output is a
  // flop and sel only toggles while address and data are held steady.
  always_comb begin
    estado_d    = estado_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rest_d      = rest_q;
    dato_d      = dato_q;
    direccion_d = direccion_q;
    sel_d       = 1'b0;
    ocupado_d   = 1'b0;
    listo_d     = 1'b0;
    error_d     = 1'b0;
    case (estado_q)
      S_IDLE: begin
        if (inicio) begin
          src_d  = origen % PROF;
          dst_d  = destino % PROF;
          rest_d = longitud;
          if (longitud > PROF) begin
            estado_d = S_ERR;
            error_d  = 1'b1;
          end else if (longitud == '0) begin
            estado_d = S_FIN;
            listo_d  = 1'b1;
          end else begin
            estado_d    = S_LEER;
            ocupado_d   = 1'b1;
            direccion_d = origen % PROF;
          end
        end
      end
      S_LEER: begin
        estado_d    = S_PREP;
        ocupado_d   = 1'b1;
        direccion_d = dst_q;
        dato_d      = salida;
      end
      S_PREP: begin
        estado_d  = S_ESCRIBIR;
        ocupado_d = 1'b1;
        sel_d     = 1'b1;
      end
      S_ESCRIBIR: begin
        estado_d  = S_LIBERAR;
        ocupado_d = 1'b1;
      end
      S_LIBERAR: begin
        src_d  = siguiente(src_q);
        dst_d  = siguiente(dst_q);
        rest_d = rest_q - UNO;
        if (rest_q == UNO) begin
          estado_d = S_FIN;
          listo_d  = 1'b1;
        end else begin
          estado_d    = S_LEER;
          ocupado_d   = 1'b1;
          direccion_d = siguiente(src_q);
        end
      end
      S_FIN:   estado_d = S_IDLE;
      S_ERR:   estado_d = S_IDLE;
      default: estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rest_q      <= '0;
      dato_q      <= '0;
      direccion_q <= '0;
      sel_q       <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rest_q      <= rest_d;
      dato_q      <= dato_d;
      direccion_q <= direccion_d;
      sel_q       <= sel_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      error_q     <= error_d;
    end
  end

  assign dato      = dato_q;
  assign direccion = direccion_q;
  assign sel       = sel_q;
  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_copiador_memoria.sv
// ============================================================================
// Module   : tb_copiador_memoria
// Desc     : Bench for copiador_memoria with a behavioural Memoria responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_copiador_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [31:0] origen, destino, longitud;
  logic [31:0] salida, dato, direccion;
  logic        sel, ocupado, listo, error;

  logic [31:0] mem  [0:63];
  logic [31:0] refm [0:63];

  logic        sel_prev;
  logic [31:0] dir_prev, dato_prev;

  int n_checks = 0;
  int n_errors = 0;

  copiador_memoria dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .origen    (origen),
    .destino   (destino),
    .longitud  (longitud),
    .salida    (salida),
    .dato      (dato),
    .direccion (direccion),
    .sel       (sel),
    .ocupado   (ocupado),
    .listo     (listo),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Memoria: combinational read
  assign salida = mem[direccion[5:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards apply the level-sensitive memory write and check
  // that sel never toggles together with the address/data bus.
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset && (sel !== sel_prev))
      chk("sel_vs_bus", 64'((direccion !== dir_prev) || (dato !== dato_prev)), 64'd0);
    if (sel === 1'b1) mem[direccion[5:0]] = dato;
    sel_prev  = sel;
    dir_prev  = direccion;
    dato_prev = dato;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input int rst_at, input bit glitch);
    int unsigned so, dof, n, nw, ev, lim;
    int  ocu_bad, lis_bad, err_bad, sel_cnt, mem_bad;
    bit  rechazo;
    logic exp_ocu;
    so      = s % 64;
    dof     = d % 64;
    rechazo = (l > 64);
    n       = rechazo ? 0 : l;
    nw      = (rst_at != 0) ? (rst_at + 1) / 4 : n;
    for (int i = 0; i < 64; i++) refm[i] = mem[i];
    for (int unsigned i = 0; i < nw; i++) refm[(dof + i) % 64] = refm[(so + i) % 64];
    ev  = rechazo ? 1 : 4 * n + 1;
    lim = ev + 1;
    ocu_bad = 0; lis_bad = 0; err_bad = 0; sel_cnt = 0; mem_bad = 0;

    origen = s; destino = d; longitud = l; inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int unsigned k = 1; k <= lim; k++) begin
      exp_ocu = !rechazo && (k <= 4 * n);
      if (ocupado !== exp_ocu) ocu_bad++;
      if (listo !== (!rechazo && k == ev)) lis_bad++;
      if (error !== (rechazo && k == 1)) err_bad++;
      if (sel === 1'b1) sel_cnt++;
      if (rst_at != 0 && k == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_ocupado", 64'(ocupado), 64'd0);
        chk("rst_direccion", 64'(direccion), 64'd0);
        for (int j = 0; j < 6; j++) begin
          if (listo !== 1'b0 || sel !== 1'b0) lis_bad++;
          step();
        end
        chk("rst_sin_listo", 64'(lis_bad), 64'd0);
        for (int i = 0; i < 64; i++) if (mem[i] !== refm[i]) mem_bad++;
        chk("rst_memoria", 64'(mem_bad), 64'd0);
        return;
      end
      if (k < lim) begin
        if (glitch && k <= 4 * n && $urandom_range(3) == 0) begin
          inicio   = 1'b1;
          origen   = $urandom;
          destino  = $urandom;
          longitud = $urandom_range(66);
        end else begin
          inicio = 1'b0;
        end
        step();
      end
    end
    inicio = 1'b0;
    chk("ocupado_ventana", 64'(ocu_bad), 64'd0);
    chk("listo_ciclo", 64'(lis_bad), 64'd0);
    chk("error_ciclo", 64'(err_bad), 64'd0);
    chk("ciclos_sel", 64'(sel_cnt), 64'(n));
    for (int i = 0; i < 64; i++) if (mem[i] !== refm[i]) mem_bad++;
    chk("memoria", 64'(mem_bad), 64'd0);
  endtask

  initial begin
    logic [31:0] x;
    reset = 1'b1; inicio = 1'b0;
    origen = '0; destino = '0; longitud = '0;
    sel_prev = 1'b0; dir_prev = '0; dato_prev = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    step();
    step();
    chk("rst_dato", 64'(dato), 64'd0);
    chk("rst_dir", 64'(direccion), 64'd0);
    chk("rst_sel0", 64'(sel), 64'd0);
    chk("rst_ocu0", 64'(ocupado), 64'd0);
    chk("rst_listo0", 64'(listo), 64'd0);
    chk("rst_error0", 64'(error), 64'd0);
    reset = 1'b0;
    step();

    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
    run_copy(32'd0, 32'd32, 32'd4, 0, 1'b0);
    chk("copia_32", 64'(mem[32]), 64'h0000_0000_AAAA_0001);
    chk("copia_35", 64'(mem[35]), 64'h0000_0000_DDDD_0004);
    chk("origen_intacto", 64'(mem[3]), 64'h0000_0000_DDDD_0004);

    run_copy(32'd3, 32'd7, 32'd0, 0, 1'b0);
    run_copy(32'd3, 32'd7, 32'd65, 0, 1'b0);
    run_copy(32'd9, 32'd50, 32'd64, 0, 1'b0);

    x = mem[62];
    run_copy(32'd62, 32'd10, 32'd4, 0, 1'b0);
    chk("wrap_10", 64'(mem[10]), 64'(x));

    x = 32'h5A5A_1234;
    mem[5] = x;
    run_copy(32'd5, 32'd6, 32'd3, 0, 1'b0);
    chk("solape_8", 64'(mem[8]), 64'(x));

    run_copy(32'd20, 32'd40, 32'd4, 0, 1'b1);

    for (int r = 0; r < 20; r++)
      run_copy($urandom, $urandom, $urandom_range(66), 0, 1'b1);

    run_copy(32'd20, 32'd40, 32'd4, 11, 1'b0);
    run_copy(32'd100, 32'd1, 32'd5, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
